nts_engine_tx_buffer: RTL and testbench

- Per-engine transmit packet buffer: the engine's TX path writes one response packet (64-bit words); the extractor reads it out over the engine TX FIFO interface (packet_available / packet_read / fifo_empty / rd_start / rd_valid / rd_data / bytes_last_word).
- Instantiated once inside each nts_engine; holds exactly one packet; retransmit by re-issuing rd_start is supported.

---
 rtl/nts_engine_pkg.sv | 14 +
 rtl/nts_tx_buffer_ram.sv | 37 +++
 rtl/nts_engine_tx_buffer.sv | 225 ++++++++++++++++++++++
 tb/tb_nts_engine_tx_buffer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nts_engine_pkg.sv
// Shared NTS engine definitions: TX buffer state encoding and datapath widths.
package nts_engine_pkg;

    localparam int LAST_DATA_VALID_WIDTH = 4;
    localparam int MAC_DATA_WIDTH        = 64;

    typedef enum logic [1:0] {
        ST_EMPTY     = 2'd0,
        ST_WRITING   = 2'd1,
        ST_AVAILABLE = 2'd2,
        ST_READING   = 2'd3
    } tx_buf_state_e;

endpackage

// File: rtl/nts_tx_buffer_ram.sv
// Simple dual-port packet RAM: one write port, one read port with a registered read.
module nts_tx_buffer_ram #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  i_clk,
    input  logic                  i_areset,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] mem_q [0:(2**ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Storage array; contents are deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    // Read register; reset so the streamed data output starts at zero.
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            rdata_q <= {DATA_WIDTH{1'b0}};
        end else if (i_re) begin
            rdata_q <= mem_q[i_raddr];
        end
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/nts_engine_tx_buffer.sv
// Single-packet TX buffer between the engine TX path and the extractor FIFO interface.
// Optional statistics counters are built when NTS_TX_BUFFER_STATS_EN is defined.
module nts_engine_tx_buffer
    import nts_engine_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int MAC_DATA_WIDTH = nts_engine_pkg::MAC_DATA_WIDTH
) (
    input  logic                             i_clk,
    input  logic                             i_areset,
    input  logic                             i_write_en,
    input  logic [MAC_DATA_WIDTH-1:0]        i_write_data,
    input  logic                             i_write_last,
    input  logic [LAST_DATA_VALID_WIDTH-1:0] i_write_bytes_last_word,
    input  logic                             i_write_discard,
    output logic                             o_write_ready,
    output logic                             o_packet_available,
    input  logic                             i_packet_read,
    output logic                             o_fifo_empty,
    input  logic                             i_fifo_rd_start,
    output logic                             o_fifo_rd_valid,
    output logic [MAC_DATA_WIDTH-1:0]        o_fifo_rd_data,
    output logic [LAST_DATA_VALID_WIDTH-1:0] o_bytes_last_word
`ifdef NTS_TX_BUFFER_STATS_EN
    ,
    output logic [31:0]                      o_stat_committed,
    output logic [31:0]                      o_stat_dropped
`endif
);

    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    tx_buf_state_e                    state_q, state_d;
    logic [CNT_W-1:0]                 count_q, count_d;
    logic [CNT_W-1:0]                 rd_ptr_q, rd_ptr_d;
    logic                             ovf_q, ovf_d;
    logic [LAST_DATA_VALID_WIDTH-1:0] blw_q, blw_d;
    logic                             rd_valid_q, rd_valid_d;
    logic                             fifo_empty_q, fifo_empty_d;
    logic                             write_ready_q, packet_available_q;

    logic                             ram_we;
    logic [ADDR_WIDTH-1:0]            ram_waddr;
    logic                             ram_re;
    logic [ADDR_WIDTH-1:0]            ram_raddr;
    logic                             word_ovf_s;

    nts_tx_buffer_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (MAC_DATA_WIDTH)
    ) u_ram (
        .i_clk    (i_clk),
        .i_areset (i_areset),
        .i_we     (ram_we),
        .i_waddr  (ram_waddr),
        .i_wdata  (i_write_data),
        .i_re     (ram_re),
        .i_raddr  (ram_raddr),
        .o_rdata  (o_fifo_rd_data)
    );

    // Next-state, pointer and RAM-control logic for the buffer FSM.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        rd_ptr_d     = rd_ptr_q;
        ovf_d        = ovf_q;
        blw_d        = blw_q;
        rd_valid_d   = 1'b0;
        fifo_empty_d = fifo_empty_q;
        ram_we       = 1'b0;
        ram_waddr    = count_q[ADDR_WIDTH-1:0];
        ram_re       = 1'b0;
        ram_raddr    = rd_ptr_q[ADDR_WIDTH-1:0];
        word_ovf_s   = count_q[ADDR_WIDTH];

        case (state_q)
            ST_EMPTY: begin
                if (i_write_en && !i_write_discard) begin
                    ram_we    = 1'b1;
                    ram_waddr = {ADDR_WIDTH{1'b0}};
                    count_d   = CNT_ONE;
                    ovf_d     = 1'b0;
                    if (i_write_last) begin
                        state_d      = ST_AVAILABLE;
                        blw_d        = i_write_bytes_last_word;
                        fifo_empty_d = 1'b0;
                    end else begin
                        state_d = ST_WRITING;
                    end
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_WRITING: begin
                if (i_write_discard) begin
                    state_d = ST_EMPTY;
                    count_d = {CNT_W{1'b0}};
                    ovf_d   = 1'b0;
                end else if (i_write_en) begin
                    // A full buffer keeps counting as overflowed; the packet dies at its last word.
                    if (word_ovf_s) begin
                        ovf_d = 1'b1;
                    end else begin
                        ram_we  = 1'b1;
                        count_d = count_q + CNT_ONE;
                    end
                    if (i_write_last) begin
                        if (ovf_q || word_ovf_s) begin
                            state_d = ST_EMPTY;
                            count_d = {CNT_W{1'b0}};
                            ovf_d   = 1'b0;
                        end else begin
                            state_d      = ST_AVAILABLE;
                            blw_d        = i_write_bytes_last_word;
                            fifo_empty_d = 1'b0;
                        end
                    end else begin
                        state_d = ST_WRITING;
                    end
                end else begin
                    state_d = ST_WRITING;
                end
            end
            ST_AVAILABLE: begin
                if (i_packet_read) begin
                    state_d      = ST_EMPTY;
                    count_d      = {CNT_W{1'b0}};
                    blw_d        = {LAST_DATA_VALID_WIDTH{1'b0}};
                    fifo_empty_d = 1'b1;
                end else if (i_fifo_rd_start) begin
                    state_d      = ST_READING;
                    ram_re       = 1'b1;
                    ram_raddr    = {ADDR_WIDTH{1'b0}};
                    rd_ptr_d     = CNT_ONE;
                    rd_valid_d   = 1'b1;
                    fifo_empty_d = 1'b0;
                end else begin
                    state_d = ST_AVAILABLE;
                end
            end
            ST_READING: begin
                if (i_packet_read) begin
                    state_d      = ST_EMPTY;
                    count_d      = {CNT_W{1'b0}};
                    blw_d        = {LAST_DATA_VALID_WIDTH{1'b0}};
                    fifo_empty_d = 1'b1;
                end else if (rd_ptr_q < count_q) begin
                    ram_re     = 1'b1;
                    rd_valid_d = 1'b1;
                    rd_ptr_d   = rd_ptr_q + CNT_ONE;
                end else begin
                    state_d      = ST_AVAILABLE;
                    fifo_empty_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // State, pointer and registered-output flops.
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            state_q            <= ST_EMPTY;
            count_q            <= {CNT_W{1'b0}};
            rd_ptr_q           <= {CNT_W{1'b0}};
            ovf_q              <= 1'b0;
            blw_q              <= {LAST_DATA_VALID_WIDTH{1'b0}};
            rd_valid_q         <= 1'b0;
            fifo_empty_q       <= 1'b1;
            write_ready_q      <= 1'b1;
            packet_available_q <= 1'b0;
        end else begin
            state_q            <= state_d;
            count_q            <= count_d;
            rd_ptr_q           <= rd_ptr_d;
            ovf_q              <= ovf_d;
            blw_q              <= blw_d;
            rd_valid_q         <= rd_valid_d;
            fifo_empty_q       <= fifo_empty_d;
            write_ready_q      <= (state_d == ST_EMPTY) || (state_d == ST_WRITING);
            packet_available_q <= (state_d == ST_AVAILABLE) || (state_d == ST_READING);
        end
    end

    assign o_write_ready      = write_ready_q;
    assign o_packet_available = packet_available_q;
    assign o_fifo_empty       = fifo_empty_q;
    assign o_fifo_rd_valid    = rd_valid_q;
    assign o_bytes_last_word  = blw_q;

`ifdef NTS_TX_BUFFER_STATS_EN
    logic [31:0] stat_committed_q;
    logic [31:0] stat_dropped_q;
    logic        commit_s;
    logic        drop_s;

    // Commit and drop events derived from the state transition.
    always_comb begin
        commit_s = (state_d == ST_AVAILABLE) &&
                   ((state_q == ST_EMPTY) || (state_q == ST_WRITING));
        drop_s   = ((state_q == ST_WRITING) && (state_d == ST_EMPTY)) ||
                   ((state_q == ST_EMPTY) && i_write_en && i_write_discard) ||
                   (!write_ready_q && i_write_en);
    end

    // Wrapping statistics counters.
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            stat_committed_q <= 32'd0;
            stat_dropped_q   <= 32'd0;
        end else begin
            stat_committed_q <= stat_committed_q + {31'd0, commit_s};
            stat_dropped_q   <= stat_dropped_q + {31'd0, drop_s};
        end
    end

    assign o_stat_committed = stat_committed_q;
    assign o_stat_dropped   = stat_dropped_q;
`endif

endmodule

// File: tb/tb_nts_engine_tx_buffer.sv
// Self-checking bench for nts_engine_tx_buffer: packet table plus corner-case sequences.
module tb_nts_engine_tx_buffer;
    import nts_engine_pkg::*;

    logic        clk;
    logic        i_areset;
    logic        i_write_en;
    logic [63:0] i_write_data;
    logic        i_write_last;
    logic [3:0]  i_write_bytes_last_word;
    logic        i_write_discard;
    logic        o_write_ready;
    logic        o_packet_available;
    logic        i_packet_read;
    logic        o_fifo_empty;
    logic        i_fifo_rd_start;
    logic        o_fifo_rd_valid;
    logic [63:0] o_fifo_rd_data;
    logic [3:0]  o_bytes_last_word;
`ifdef NTS_TX_BUFFER_STATS_EN
    logic [31:0] stat_committed;
    logic [31:0] stat_dropped;
`endif

    int checks = 0;
    int errors = 0;
    logic [63:0] sb[$];

    typedef struct {
        int          nwords;
        logic [3:0]  blw;
        logic [63:0] seed;
        int          nstreams;
        bit          exp_avail;
    } vec_t;

    vec_t tbl[5];

    nts_engine_tx_buffer dut (
        .i_clk                   (clk),
        .i_areset                (i_areset),
        .i_write_en              (i_write_en),
        .i_write_data            (i_write_data),
        .i_write_last            (i_write_last),
        .i_write_bytes_last_word (i_write_bytes_last_word),
        .i_write_discard         (i_write_discard),
        .o_write_ready           (o_write_ready),
        .o_packet_available      (o_packet_available),
        .i_packet_read           (i_packet_read),
        .o_fifo_empty            (o_fifo_empty),
        .i_fifo_rd_start         (i_fifo_rd_start),
        .o_fifo_rd_valid         (o_fifo_rd_valid),
        .o_fifo_rd_data          (o_fifo_rd_data),
        .o_bytes_last_word       (o_bytes_last_word)
`ifdef NTS_TX_BUFFER_STATS_EN
        ,
        .o_stat_committed        (stat_committed),
        .o_stat_dropped          (stat_dropped)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Scoreboard: every streamed word is compared with the oldest expected word.
    always @(posedge clk) begin
        #2;
        if (o_fifo_rd_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected actual=%h required=no_valid", o_fifo_rd_data);
            end else begin
                chk("rd_data", o_fifo_rd_data, sb.pop_front());
            end
        end
    end

    function automatic logic [63:0] word_of(input logic [63:0] seed, input int idx);
        return seed * 64'(idx + 1);
    endfunction

    task automatic write_pkt(input int n, input logic [3:0] blw, input logic [63:0] seed);
        for (int i = 0; i < n; i++) begin
            i_write_en              = 1'b1;
            i_write_data            = word_of(seed, i);
            i_write_last            = (i == n - 1);
            i_write_bytes_last_word = blw;
            @(negedge clk);
        end
        i_write_en   = 1'b0;
        i_write_last = 1'b0;
    endtask

    task automatic stream(input int n, input logic [63:0] seed);
        i_fifo_rd_start = 1'b1;
        for (int i = 0; i < n; i++) sb.push_back(word_of(seed, i));
        @(negedge clk);
        i_fifo_rd_start = 1'b0;
        for (int k = 1; k <= n; k++) begin
            chk("rd_valid_on", {63'd0, o_fifo_rd_valid}, 64'd1);
            chk("fifo_empty_streaming", {63'd0, o_fifo_empty}, 64'd0);
            @(negedge clk);
        end
        chk("rd_valid_off", {63'd0, o_fifo_rd_valid}, 64'd0);
        chk("fifo_empty_after", {63'd0, o_fifo_empty}, 64'd1);
        chk("avail_after_stream", {63'd0, o_packet_available}, 64'd1);
        chk("sb_drained", 64'(sb.size()), 64'd0);
    endtask

    task automatic release_pkt();
        i_packet_read = 1'b1;
        @(negedge clk);
        i_packet_read = 1'b0;
        chk("rel_avail", {63'd0, o_packet_available}, 64'd0);
        chk("rel_ready", {63'd0, o_write_ready}, 64'd1);
        chk("rel_empty", {63'd0, o_fifo_empty}, 64'd1);
        chk("rel_blw", {60'd0, o_bytes_last_word}, 64'd0);
    endtask

    initial begin
        tbl[0] = '{3,   4'd5, 64'h1111_1111_1111_1111, 2, 1'b1};
        tbl[1] = '{1,   4'd8, 64'hdead_beef_0000_0001, 1, 1'b1};
        tbl[2] = '{256, 4'd1, 64'h0123_4567_89ab_cdef, 1, 1'b1};
        tbl[3] = '{257, 4'd4, 64'h0f0f_0f0f_0f0f_0f0f, 0, 1'b0};
        tbl[4] = '{4,   4'd3, 64'h5555_aaaa_3333_cccd, 1, 1'b1};

        i_areset = 1'b1;
        i_write_en = 1'b0;
        i_write_data = 64'd0;
        i_write_last = 1'b0;
        i_write_bytes_last_word = 4'd0;
        i_write_discard = 1'b0;
        i_packet_read = 1'b0;
        i_fifo_rd_start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {63'd0, o_write_ready}, 64'd1);
        chk("rst_avail", {63'd0, o_packet_available}, 64'd0);
        chk("rst_empty", {63'd0, o_fifo_empty}, 64'd1);
        chk("rst_valid", {63'd0, o_fifo_rd_valid}, 64'd0);
        chk("rst_data", o_fifo_rd_data, 64'd0);
        chk("rst_blw", {60'd0, o_bytes_last_word}, 64'd0);
        i_areset = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            write_pkt(tbl[v].nwords, tbl[v].blw, tbl[v].seed);
            chk("tbl_avail", {63'd0, o_packet_available}, {63'd0, tbl[v].exp_avail});
            chk("tbl_ready", {63'd0, o_write_ready}, {63'd0, ~tbl[v].exp_avail});
            if (tbl[v].exp_avail) begin
                chk("tbl_blw", {60'd0, o_bytes_last_word}, {60'd0, tbl[v].blw});
                chk("tbl_empty", {63'd0, o_fifo_empty}, 64'd0);
                for (int s = 0; s < tbl[v].nstreams; s++) stream(tbl[v].nwords, tbl[v].seed);
                release_pkt();
            end else begin
                chk("drop_empty", {63'd0, o_fifo_empty}, 64'd1);
                @(negedge clk);
                chk("drop_stays", {63'd0, o_packet_available}, 64'd0);
            end
        end

        // Discard after two words, then a single-word packet commits at once.
        i_write_en = 1'b1;
        i_write_data = 64'haaaa_0000_0000_0001;
        @(negedge clk);
        i_write_data = 64'haaaa_0000_0000_0002;
        @(negedge clk);
        i_write_en = 1'b0;
        i_write_discard = 1'b1;
        @(negedge clk);
        i_write_discard = 1'b0;
        chk("disc_ready", {63'd0, o_write_ready}, 64'd1);
        chk("disc_avail", {63'd0, o_packet_available}, 64'd0);
        write_pkt(1, 4'd6, 64'h7777_0000_0000_0007);
        chk("one_avail", {63'd0, o_packet_available}, 64'd1);
        chk("one_blw", {60'd0, o_bytes_last_word}, 64'd6);
        stream(1, 64'h7777_0000_0000_0007);

        // A write while a packet is held must change nothing.
        i_write_en = 1'b1;
        i_write_last = 1'b1;
        i_write_data = 64'hffff_ffff_ffff_ffff;
        i_write_bytes_last_word = 4'd2;
        chk("held_not_ready", {63'd0, o_write_ready}, 64'd0);
        @(negedge clk);
        i_write_en = 1'b0;
        i_write_last = 1'b0;
        chk("held_blw", {60'd0, o_bytes_last_word}, 64'd6);
        stream(1, 64'h7777_0000_0000_0007);

        // packet_read and rd_start together: the release wins.
        i_packet_read = 1'b1;
        i_fifo_rd_start = 1'b1;
        @(negedge clk);
        i_packet_read = 1'b0;
        i_fifo_rd_start = 1'b0;
        chk("both_avail", {63'd0, o_packet_available}, 64'd0);
        chk("both_valid", {63'd0, o_fifo_rd_valid}, 64'd0);
        chk("both_ready", {63'd0, o_write_ready}, 64'd1);

        // Abort a 4-word stream at its second valid word.
        write_pkt(4, 4'd7, 64'h0bad_cafe_0000_0011);
        i_fifo_rd_start = 1'b1;
        for (int i = 0; i < 4; i++) sb.push_back(word_of(64'h0bad_cafe_0000_0011, i));
        @(negedge clk);
        i_fifo_rd_start = 1'b0;
        @(negedge clk);
        chk("abort_second_valid", {63'd0, o_fifo_rd_valid}, 64'd1);
        i_packet_read = 1'b1;
        @(negedge clk);
        i_packet_read = 1'b0;
        sb.delete();
        chk("abort_valid", {63'd0, o_fifo_rd_valid}, 64'd0);
        chk("abort_avail", {63'd0, o_packet_available}, 64'd0);
        chk("abort_empty", {63'd0, o_fifo_empty}, 64'd1);
        chk("abort_ready", {63'd0, o_write_ready}, 64'd1);

        // Asynchronous reset in the middle of a stream.
        write_pkt(4, 4'd2, 64'h1234_0000_0000_0003);
        i_fifo_rd_start = 1'b1;
        for (int i = 0; i < 4; i++) sb.push_back(word_of(64'h1234_0000_0000_0003, i));
        @(negedge clk);
        i_fifo_rd_start = 1'b0;
        @(negedge clk);
        i_areset = 1'b1;
        #1;
        sb.delete();
        chk("arst_valid", {63'd0, o_fifo_rd_valid}, 64'd0);
        chk("arst_data", o_fifo_rd_data, 64'd0);
        chk("arst_avail", {63'd0, o_packet_available}, 64'd0);
        chk("arst_empty", {63'd0, o_fifo_empty}, 64'd1);
        chk("arst_ready", {63'd0, o_write_ready}, 64'd1);
        chk("arst_blw", {60'd0, o_bytes_last_word}, 64'd0);
        @(negedge clk);
        i_areset = 1'b0;
        @(negedge clk);
        write_pkt(2, 4'd8, 64'h0000_0000_0000_0abd);
        chk("post_rst_avail", {63'd0, o_packet_available}, 64'd1);
        chk("post_rst_blw", {60'd0, o_bytes_last_word}, 64'd8);
        stream(2, 64'h0000_0000_0000_0abd);
        release_pkt();

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
